// File: rtl/bus_control_sync_8259_if.sv
// rtl/bus_control_sync_8259_if.sv - CPU bus and command-strobe bundle for the synchronous 8259 bus control
// Optional BUS_ERROR_EN adds protocol_error.
interface bus_control_sync_8259_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  chip_select_n;
    logic                  read_enable_n;
    logic                  write_enable_n;
    logic                  address;
    logic [DATA_WIDTH-1:0] data_bus_in;
    logic [DATA_WIDTH-1:0] internal_data_bus;
    logic                  write_initial_command_word_1;
    logic                  write_initial_command_word_2;
    logic                  write_initial_command_word_3;
    logic                  write_initial_command_word_4;
    logic                  write_operation_control_word_1;
    logic                  write_operation_control_word_2;
    logic                  write_operation_control_word_3;
    logic                  read;
    logic                  read_start;
    logic                  init_done;
`ifdef BUS_ERROR_EN
    logic                  protocol_error;
`endif

    modport slave (
        input  chip_select_n, read_enable_n, write_enable_n, address, data_bus_in,
        output internal_data_bus,
        output write_initial_command_word_1, write_initial_command_word_2,
        output write_initial_command_word_3, write_initial_command_word_4,
        output write_operation_control_word_1, write_operation_control_word_2,
        output write_operation_control_word_3,
`ifdef BUS_ERROR_EN
        output protocol_error,
`endif
        output read, read_start, init_done
    );

    modport master (
        output chip_select_n, read_enable_n, write_enable_n, address, data_bus_in,
        input  internal_data_bus,
        input  write_initial_command_word_1, write_initial_command_word_2,
        input  write_initial_command_word_3, write_initial_command_word_4,
        input  write_operation_control_word_1, write_operation_control_word_2,
        input  write_operation_control_word_3,
`ifdef BUS_ERROR_EN
        input  protocol_error,
`endif
        input  read, read_start, init_done
    );
endinterface

// File: rtl/bus_control_sync_8259.sv
// rtl/bus_control_sync_8259.sv - clocked 8259 bus control: strobe sync, write capture, ICW/OCW decode FSM
// Optional macro BUS_ERROR_EN adds the protocol_error pulse output.
module bus_control_sync_8259 #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                   clock,
    input logic                   reset_n,
    bus_control_sync_8259_if.slave bus
);
    if (DATA_WIDTH < 8 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_param
        $error("bus_control_sync_8259: illegal DATA_WIDTH or SYNC_STAGES");
    end

    localparam logic [2:0] ST_UNINIT = 3'd0;
    localparam logic [2:0] ST_WAIT2  = 3'd1;
    localparam logic [2:0] ST_WAIT3  = 3'd2;
    localparam logic [2:0] ST_WAIT4  = 3'd3;
    localparam logic [2:0] ST_READY  = 3'd4;

    logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;
    logic                   cs_s, rd_s, wr_s;
    logic [DATA_WIDTH-1:0]  hold_data_q, internal_q;
    logic                   hold_addr_q, write_pending_q;
    logic [2:0]             state_q, state_d;
    logic                   sngl_q, sngl_d, ic4_q, ic4_d;
    logic [6:0]             strobe_q, strobe_d;
    logic                   read_q, read_d, read_start_q, init_done_q;
    logic                   capture, accept, drop_d;

    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign rd_s    = rd_sync_q[SYNC_STAGES-1];
    assign wr_s    = wr_sync_q[SYNC_STAGES-1];
    assign capture = !wr_s && !cs_s;
    // CS may already be high here; a captured write is always completed.
    assign accept  = wr_s && write_pending_q;
    assign read_d  = !rd_s && !cs_s && !capture && !write_pending_q;

    always_comb begin
        state_d  = state_q;
        sngl_d   = sngl_q;
        ic4_d    = ic4_q;
        strobe_d = '0;
        drop_d   = 1'b0;
        if (accept) begin
            if (!hold_addr_q && hold_data_q[4]) begin
                strobe_d[0] = 1'b1;
                sngl_d      = hold_data_q[1];
                ic4_d       = hold_data_q[0];
                state_d     = ST_WAIT2;
            end else begin
                case (state_q)
                    ST_WAIT2: begin
                        strobe_d[1] = hold_addr_q;
                        drop_d      = !hold_addr_q;
                        if (hold_addr_q)
                            state_d = !sngl_q ? ST_WAIT3 : (ic4_q ? ST_WAIT4 : ST_READY);
                    end
                    ST_WAIT3: begin
                        strobe_d[2] = hold_addr_q;
                        drop_d      = !hold_addr_q;
                        if (hold_addr_q)
                            state_d = ic4_q ? ST_WAIT4 : ST_READY;
                    end
                    ST_WAIT4: begin
                        strobe_d[3] = hold_addr_q;
                        drop_d      = !hold_addr_q;
                        if (hold_addr_q)
                            state_d = ST_READY;
                    end
                    ST_READY: begin
                        strobe_d[4] = hold_addr_q;
                        strobe_d[5] = !hold_addr_q && !hold_data_q[3];
                        strobe_d[6] = !hold_addr_q && hold_data_q[3];
                    end
                    default: drop_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cs_sync_q       <= '1;
            rd_sync_q       <= '1;
            wr_sync_q       <= '1;
            hold_data_q     <= '0;
            hold_addr_q     <= 1'b0;
            write_pending_q <= 1'b0;
            internal_q      <= '0;
            state_q         <= ST_UNINIT;
            sngl_q          <= 1'b0;
            ic4_q           <= 1'b0;
            strobe_q        <= '0;
            read_q          <= 1'b0;
            read_start_q    <= 1'b0;
            init_done_q     <= 1'b0;
        end else begin
            cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], bus.chip_select_n};
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], bus.read_enable_n};
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], bus.write_enable_n};
            if (capture) begin
                hold_data_q     <= bus.data_bus_in;
                hold_addr_q     <= bus.address;
                write_pending_q <= 1'b1;
            end else if (accept) begin
                write_pending_q <= 1'b0;
                internal_q      <= hold_data_q;
            end
            state_q      <= state_d;
            sngl_q       <= sngl_d;
            ic4_q        <= ic4_d;
            strobe_q     <= strobe_d;
            read_q       <= read_d;
            read_start_q <= read_d && !read_q;
            init_done_q  <= (state_d == ST_READY);
        end
    end

`ifdef BUS_ERROR_EN
    logic overlap_d, overlap_q, protocol_error_q;

    // Only the first clock of a suppressed-read overlap is flagged.
    assign overlap_d = !rd_s && !cs_s && (capture || write_pending_q);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overlap_q        <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            overlap_q        <= overlap_d;
            protocol_error_q <= drop_d || (overlap_d && !overlap_q);
        end
    end

    assign bus.protocol_error = protocol_error_q;
`endif

    assign bus.internal_data_bus              = internal_q;
    assign bus.write_initial_command_word_1   = strobe_q[0];
    assign bus.write_initial_command_word_2   = strobe_q[1];
    assign bus.write_initial_command_word_3   = strobe_q[2];
    assign bus.write_initial_command_word_4   = strobe_q[3];
    assign bus.write_operation_control_word_1 = strobe_q[4];
    assign bus.write_operation_control_word_2 = strobe_q[5];
    assign bus.write_operation_control_word_3 = strobe_q[6];
    assign bus.read                           = read_q;
    assign bus.read_start                     = read_start_q;
    assign bus.init_done                      = init_done_q;
endmodule

// File: tb/tb_bus_control_sync_8259.sv
// tb/tb_bus_control_sync_8259.sv - randomized self-checking bench for bus_control_sync_8259
module tb_bus_control_sync_8259;
    localparam int SYNC_STAGES = 2;
    localparam int DW          = 8;
    localparam int WIN         = SYNC_STAGES + 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    bus_control_sync_8259_if #(.DATA_WIDTH(DW)) bus ();

    bus_control_sync_8259 #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [6:0] stb;
    assign stb = {bus.write_operation_control_word_3, bus.write_operation_control_word_2,
                  bus.write_operation_control_word_1, bus.write_initial_command_word_4,
                  bus.write_initial_command_word_3, bus.write_initial_command_word_2,
                  bus.write_initial_command_word_1};

    int checks = 0;
    int errors = 0;

    // Reference model: list of ICW numbers still owed after ICW1 (1=ICW2, 2=ICW3, 3=ICW4).
    bit         m_started;
    int         m_todo[$];
    logic [7:0] m_bus;

    function automatic int model_write(input logic a, input logic [7:0] d);
        int idx;
        m_bus = d;
        if (!a && d[4]) begin
            m_started = 1'b1;
            m_todo.delete();
            m_todo.push_back(1);
            if (!d[1]) m_todo.push_back(2);
            if (d[0])  m_todo.push_back(3);
            idx = 0;
        end else if (!m_started) begin
            idx = -1;
        end else if (m_todo.size() != 0) begin
            idx = a ? m_todo.pop_front() : -1;
        end else begin
            idx = a ? 4 : (d[3] ? 6 : 5);
        end
        return idx;
    endfunction

    function automatic logic model_ready();
        return m_started && (m_todo.size() == 0);
    endfunction

    function automatic logic [6:0] onehot(input int idx);
        return (idx < 0) ? 7'd0 : 7'(1 << idx);
    endfunction

    function automatic void model_reset();
        m_started = 1'b0;
        m_todo.delete();
        m_bus = 8'h00;
    endfunction

    logic [6:0] obs_vec;
    int         obs_cnt, obs_lat, obs_perr, obs_read_early, obs_rs;
    logic       obs_read_end;

    // Drives one CPU write (called at posedge+1) and records what the DUT emitted.
    task automatic do_write(input logic a, input logic [7:0] d, input int low,
                            input bit early, input bit with_rd);
        obs_vec = '0; obs_cnt = 0; obs_lat = -1; obs_perr = 0; obs_read_early = 0; obs_rs = 0;
        bus.address = a; bus.data_bus_in = d;
        bus.chip_select_n = 1'b0; bus.write_enable_n = 1'b0;
        if (with_rd) bus.read_enable_n = 1'b0;
        for (int k = 0; k < low; k++) begin
            @(negedge clock);
            if (stb != 0) begin obs_cnt++; obs_vec |= stb; end
            if (bus.read) obs_read_early++;
            if (bus.read_start) obs_rs++;
`ifdef BUS_ERROR_EN
            if (bus.protocol_error) obs_perr++;
`endif
            @(posedge clock); #1;
            if (early && k == low - 2) bus.chip_select_n = 1'b1;
        end
        bus.write_enable_n = 1'b1;
        for (int i = 1; i <= WIN; i++) begin
            @(negedge clock);
            if (stb != 0) begin obs_cnt++; obs_vec |= stb; obs_lat = i - 1; end
            if (bus.read && i <= SYNC_STAGES + 2) obs_read_early++;
            if (bus.read_start) obs_rs++;
`ifdef BUS_ERROR_EN
            if (bus.protocol_error) obs_perr++;
`endif
        end
        obs_read_end = bus.read;
        @(posedge clock); #1;
        bus.chip_select_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.chip_select_n = 1'b1; bus.read_enable_n = 1'b1; bus.write_enable_n = 1'b1;
        bus.address = 1'b0; bus.data_bus_in = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({stb, bus.read, bus.read_start, bus.init_done, bus.internal_data_bus} !== '0) begin
            errors++;
            $display("FAIL reset outputs got stb=%b rd=%b rs=%b init=%b bus=%h required all 0",
                     stb, bus.read, bus.read_start, bus.init_done, bus.internal_data_bus);
        end
`ifdef BUS_ERROR_EN
        checks++;
        if (bus.protocol_error !== 1'b0) begin
            errors++; $display("FAIL reset protocol_error got %b required 0", bus.protocol_error);
        end
`endif
        model_reset();
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_icw_sngl_ic4();
        logic       a_t[3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] d_t[3] = '{8'h13, 8'h20, 8'h01};
        int exp;
        for (int i = 0; i < 3; i++) begin
            exp = model_write(a_t[i], d_t[i]);
            do_write(a_t[i], d_t[i], 2, 1'b0, 1'b0);
            checks++;
            if (obs_vec !== onehot(exp) || obs_cnt != (exp >= 0 ? 1 : 0)) begin
                errors++;
                $display("FAIL icw_single[%0d] strobes got %b x%0d required %b", i, obs_vec, obs_cnt, onehot(exp));
            end
            checks++;
            if (bus.init_done !== model_ready() || bus.internal_data_bus !== m_bus) begin
                errors++;
                $display("FAIL icw_single[%0d] init_done/bus got %b/%h required %b/%h",
                         i, bus.init_done, bus.internal_data_bus, model_ready(), m_bus);
            end
        end
    endtask

    task automatic test_cascade_ocw();
        logic       a_t[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] d_t[6] = '{8'h10, 8'h08, 8'h04, 8'hFF, 8'h20, 8'h0B};
        int exp;
        for (int i = 0; i < 6; i++) begin
            exp = model_write(a_t[i], d_t[i]);
            do_write(a_t[i], d_t[i], 3, 1'b0, 1'b0);
            checks++;
            if (obs_vec !== onehot(exp) || obs_cnt != (exp >= 0 ? 1 : 0)) begin
                errors++;
                $display("FAIL cascade_ocw[%0d] strobes got %b x%0d required %b", i, obs_vec, obs_cnt, onehot(exp));
            end
            checks++;
            if (bus.init_done !== model_ready() || bus.internal_data_bus !== m_bus) begin
                errors++;
                $display("FAIL cascade_ocw[%0d] init_done/bus got %b/%h required %b/%h",
                         i, bus.init_done, bus.internal_data_bus, model_ready(), m_bus);
            end
        end
    endtask

    task automatic test_uninit_drop();
        logic       a_t[2] = '{1'b1, 1'b0};
        logic [7:0] d_t[2] = '{8'h55, 8'h13};
        int exp;
        test_reset();
        for (int i = 0; i < 2; i++) begin
            exp = model_write(a_t[i], d_t[i]);
            do_write(a_t[i], d_t[i], 2, 1'b0, 1'b0);
            checks++;
            if (obs_vec !== onehot(exp) || obs_cnt != (exp >= 0 ? 1 : 0)) begin
                errors++;
                $display("FAIL uninit_drop[%0d] strobes got %b x%0d required %b", i, obs_vec, obs_cnt, onehot(exp));
            end
            checks++;
            if (bus.init_done !== model_ready() || bus.internal_data_bus !== m_bus) begin
                errors++;
                $display("FAIL uninit_drop[%0d] init_done/bus got %b/%h required %b/%h",
                         i, bus.init_done, bus.internal_data_bus, model_ready(), m_bus);
            end
`ifdef BUS_ERROR_EN
            checks++;
            if (obs_perr != (exp < 0 ? 1 : 0)) begin
                errors++; $display("FAIL uninit_drop[%0d] protocol_error pulses got %0d required %0d", i, obs_perr, exp < 0);
            end
`endif
        end
    endtask

    task automatic test_latency_cs_early();
        int exp;
        exp = model_write(1'b1, 8'h20);
        do_write(1'b1, 8'h20, 2, 1'b1, 1'b0);
        checks++;
        if (obs_vec !== onehot(exp) || obs_cnt != 1) begin
            errors++; $display("FAIL cs_early strobes got %b x%0d required %b x1", obs_vec, obs_cnt, onehot(exp));
        end
        checks++;
        if (obs_lat != SYNC_STAGES + 1) begin
            errors++; $display("FAIL latency got %0d clocks required %0d", obs_lat, SYNC_STAGES + 1);
        end
    endtask

    task automatic test_read_write_overlap();
        int exp;
        exp = model_write(1'b1, 8'h01);
        do_write(1'b1, 8'h01, 3, 1'b0, 1'b1);
        checks++;
        if (obs_vec !== onehot(exp) || obs_cnt != 1) begin
            errors++; $display("FAIL overlap strobes got %b x%0d required %b x1", obs_vec, obs_cnt, onehot(exp));
        end
        checks++;
        if (obs_read_early != 0 || obs_read_end !== 1'b1 || obs_rs != 1) begin
            errors++;
            $display("FAIL overlap read got early=%0d end=%b starts=%0d required 0/1/1", obs_read_early, obs_read_end, obs_rs);
        end
`ifdef BUS_ERROR_EN
        checks++;
        if (obs_perr != 1) begin
            errors++; $display("FAIL overlap protocol_error pulses got %0d required 1", obs_perr);
        end
`endif
        bus.read_enable_n = 1'b1;
        repeat (SYNC_STAGES + 2) @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid_write();
        int exp, cnt;
        exp = model_write(1'b0, 8'h10);
        do_write(1'b0, 8'h10, 2, 1'b0, 1'b0);
        exp = model_write(1'b1, 8'h08);
        do_write(1'b1, 8'h08, 2, 1'b0, 1'b0);
        checks++;
        if (obs_vec !== onehot(exp)) begin
            errors++; $display("FAIL midreset setup strobes got %b required %b", obs_vec, onehot(exp));
        end
        bus.address = 1'b1; bus.data_bus_in = 8'hAA;
        bus.chip_select_n = 1'b0; bus.write_enable_n = 1'b0;
        repeat (3) @(posedge clock);
        #1; reset_n = 1'b0;
        @(posedge clock); #1;
        bus.write_enable_n = 1'b1; bus.chip_select_n = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        model_reset();
        cnt = 0;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clock);
            if (stb != 0) cnt++;
        end
        @(posedge clock); #1;
        checks++;
        if (cnt != 0 || bus.init_done !== 1'b0 || bus.internal_data_bus !== 8'h00) begin
            errors++;
            $display("FAIL midreset got strobes=%0d init=%b bus=%h required 0/0/00", cnt, bus.init_done, bus.internal_data_bus);
        end
        exp = model_write(1'b1, 8'h77);
        do_write(1'b1, 8'h77, 2, 1'b0, 1'b0);
        checks++;
        if (obs_cnt != 0 || exp != -1 || bus.internal_data_bus !== m_bus) begin
            errors++;
            $display("FAIL midreset icw2 got strobes=%0d bus=%h required 0/%h", obs_cnt, bus.internal_data_bus, m_bus);
        end
    endtask

    task automatic test_back_to_back();
        int         exp1, exp2;
        logic [6:0] seen[$];
        exp1 = model_write(1'b0, 8'h12);
        do_write(1'b0, 8'h12, 2, 1'b0, 1'b0);
        exp1 = model_write(1'b1, 8'h40);
        do_write(1'b1, 8'h40, 2, 1'b0, 1'b0);
        checks++;
        if (bus.init_done !== 1'b1 || !model_ready()) begin
            errors++; $display("FAIL b2b setup init_done got %b required 1", bus.init_done);
        end
        exp1 = model_write(1'b1, 8'h3C);
        exp2 = model_write(1'b0, 8'h05);
        bus.address = 1'b1; bus.data_bus_in = 8'h3C;
        bus.chip_select_n = 1'b0; bus.write_enable_n = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (stb != 0) seen.push_back(stb);
            @(posedge clock); #1;
            case (t)
                1:  bus.write_enable_n = 1'b1;
                2:  bus.write_enable_n = 1'b0;
                3:  begin bus.address = 1'b0; bus.data_bus_in = 8'h05; end
                5:  bus.write_enable_n = 1'b1;
                12: bus.chip_select_n = 1'b1;
                default: ;
            endcase
        end
        checks++;
        if (seen.size() != 2) begin
            errors++; $display("FAIL b2b strobe count got %0d required 2", seen.size());
        end else if (seen[0] !== onehot(exp1) || seen[1] !== onehot(exp2)) begin
            errors++; $display("FAIL b2b strobes got %b,%b required %b,%b", seen[0], seen[1], onehot(exp1), onehot(exp2));
        end
        checks++;
        if (bus.internal_data_bus !== m_bus) begin
            errors++; $display("FAIL b2b bus got %h required %h", bus.internal_data_bus, m_bus);
        end
    endtask

    task automatic test_random();
        logic       a;
        logic [7:0] d;
        int         exp, low;
        bit         early;
        for (int i = 0; i < 40; i++) begin
            a = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin a = 1'b0; d[4] = 1'b1; end
            low   = $urandom_range(2, 3);
            early = 1'($urandom_range(0, 1));
            exp = model_write(a, d);
            do_write(a, d, low, early, 1'b0);
            checks++;
            if (obs_vec !== onehot(exp) || obs_cnt != (exp >= 0 ? 1 : 0) ||
                (exp >= 0 && obs_lat != SYNC_STAGES + 1)) begin
                errors++;
                $display("FAIL random[%0d] a=%b d=%h strobes got %b x%0d lat %0d required %b lat %0d",
                         i, a, d, obs_vec, obs_cnt, obs_lat, onehot(exp), SYNC_STAGES + 1);
            end
            checks++;
            if (bus.init_done !== model_ready() || bus.internal_data_bus !== m_bus) begin
                errors++;
                $display("FAIL random[%0d] init_done/bus got %b/%h required %b/%h",
                         i, bus.init_done, bus.internal_data_bus, model_ready(), m_bus);
            end
`ifdef BUS_ERROR_EN
            checks++;
            if (obs_perr != (exp < 0 ? 1 : 0)) begin
                errors++; $display("FAIL random[%0d] protocol_error pulses got %0d required %0d", i, obs_perr, exp < 0);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_icw_sngl_ic4();
        test_cascade_ocw();
        test_uninit_drop();
        test_latency_cs_early();
        test_read_write_overlap();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_control_sync_8259.md
Name: bus_control_sync_8259

Overview:
- Clocked, parametrised successor to the asynchronous 8259 data bus control.
- Synchronises the CPU bus strobes (chip_select_n, read_enable_n, write_enable_n) into the clock domain and captures write data.
- Tracks the ICW1→ICW2→[ICW3]→[ICW4] initialisation sequence in an FSM and issues single-cycle command-word strobes.
- Sits between the CPU bus pins and the interrupt control logic, which consumes the strobes and internal_data_bus.

Parameters:
- DATA_WIDTH, 8, data bus width; minimum 8; decode uses bits [4:0].
- SYNC_STAGES, 2, flops in each strobe synchroniser; legal range 2..4.

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- chip_select_n  input  1  async CPU chip select
- read_enable_n  input  1  async CPU read strobe
- write_enable_n  input  1  async CPU write strobe
- address  input  1  A0
- data_bus_in  input  DATA_WIDTH  CPU write data
- internal_data_bus  output  DATA_WIDTH  last accepted write data
- write_initial_command_word_1  output  1  ICW1 strobe, 1 clock
- write_initial_command_word_2  output  1  ICW2 strobe
- write_initial_command_word_3  output  1  ICW3 strobe
- write_initial_command_word_4  output  1  ICW4 strobe
- write_operation_control_word_1  output  1  OCW1 strobe
- write_operation_control_word_2  output  1  OCW2 strobe
- write_operation_control_word_3  output  1  OCW3 strobe
- read  output  1  level: read cycle active
- read_start  output  1  1-clock pulse at read cycle start
- init_done  output  1  initialisation sequence complete

Behaviour:
- Reset (reset_n low at a clock edge):
  - All outputs 0; internal_data_bus 0.
  - Synchronisers load 1 (inactive).
  - FSM goes to UNINIT; captured SNGL and IC4 flags cleared.
  - Reset mid-write discards the pending write; no strobe is emitted.
- Synchronisers:
  - cs_s, rd_s and wr_s are the SYNC_STAGES-deep synchronised strobes.
  - address and data_bus_in are not synchronised; they must be stable while write_enable_n is low.
- Write capture:
  - On every clock with wr_s=0 and cs_s=0: capture data_bus_in and address into holding registers and set write_pending.
- Write accept:
  - On the clock where wr_s=1 and write_pending=1: clear write_pending, copy held data to internal_data_bus, and decode.
  - Exactly one strobe is asserted on the next clock, for one clock only.
  - Latency from wr_s rising to strobe: 1 clock.
  - Deasserting CS before WR rising does not cancel the write.
- FSM decode (d = held data, a = held address):
  - Any state, a=0 and d[4]=1: ICW1.
    - Latch SNGL=d[1] and IC4=d[0].
    - Clear init_done.
    - Go to WAIT2.
  - WAIT2, a=1: ICW2.
    - Go to WAIT3 if SNGL=0.
    - Otherwise go to WAIT4 if IC4=1.
    - Otherwise go to READY.
  - WAIT3, a=1: ICW3; go to WAIT4 if IC4=1, else READY.
  - WAIT4, a=1: ICW4; go to READY.
  - READY, a=1: OCW1.
  - READY, a=0, d[4:3]=00: OCW2.
  - READY, a=0, d[4:3]=01: OCW3.
  - init_done=1 only in READY, registered.
  - Dropped writes, with no strobe and no state change:
    - UNINIT with any non-ICW1 write.
    - WAIT2/3/4 with a=0 and d[4]=0.
  - internal_data_bus is still updated on a dropped write.
- Read:
  - read is registered: ~rd_s & ~cs_s.
  - read_start pulses 1 clock on the 0→1 transition of read.
- Simultaneous read and write: if rd_s=0 and wr_s=0 with cs_s=0 in the same clock, the write wins. read is forced to 0 while write_pending=1.
- Back-to-back writes: a new WR low arriving during the strobe clock is captured normally, so no write is lost.

Optional Feature:
- Macro: BUS_ERROR_EN.
- With the macro:
  - Adds output protocol_error (1 bit, reset 0).
  - protocol_error pulses 1 clock, aligned with where a strobe would be, for each dropped write.
  - It also pulses once on the first clock where a read/write overlap suppresses read.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset; write a=0 d=0x13 (ICW1, SNGL=1, IC4=1), then a=1 0x20, then a=1 0x01. Expect ICW1, ICW2 and ICW4 strobes, no ICW3, init_done=1 after ICW4, and internal_data_bus=0x01.
2. ICW1 d=0x10 (SNGL=0, IC4=0), then ICW2 and ICW3 writes. Expect ICW3 strobe, no ICW4, init_done=1. Then a=1 0xFF gives OCW1; a=0 0x20 gives OCW2; a=0 0x0B gives OCW3.
3. After reset, write a=1 0x55. Expect no strobe, FSM stays UNINIT, and, with BUS_ERROR_EN, a protocol_error pulse. Then ICW1 0x13 is accepted.
4. Write pulse with 2-clock low time, SYNC_STAGES=2. Expect the strobe exactly SYNC_STAGES+1 clocks after the raw WR rising edge, 1 clock wide. CS raised one clock before WR rising still produces the strobe.
5. Drive RD low and WR low together with CS=0. Expect read=0 until the write is accepted, then read=1 with a single read_start pulse.
6. Pull reset_n low during WAIT3 with WR low. Expect no strobe, init_done=0, FSM in UNINIT, and a later ICW2-style write (a=1) ignored.
